// File: rtl/lm32_dtlb_walker_if.sv
// Signal bundle between the DTLB page-table walker, the pipeline/DTLB and the PTE read port.
// master = walker side, slave = environment (pipeline, DTLB, memory port).
interface lm32_dtlb_walker_if;
  logic        enable;
  logic        miss_i;
  logic [31:0] miss_address;
  logic        miss_store;
  logic [31:0] ptbr;
  logic        abort;
  logic        pte_req;
  logic [31:0] pte_addr;
  logic        pte_ack;
  logic        pte_err;
  logic [31:0] pte_data;
  logic        update;
  logic [31:0] update_vaddr;
  logic [31:0] update_paddr;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_address;
  logic        busy;

  modport master (
    input  enable, miss_i, miss_address, miss_store, ptbr, abort,
    input  pte_ack, pte_err, pte_data,
    output pte_req, pte_addr, update, update_vaddr, update_paddr,
    output fault, fault_cause, fault_address, busy
  );

  modport slave (
    output enable, miss_i, miss_address, miss_store, ptbr, abort,
    output pte_ack, pte_err, pte_data,
    input  pte_req, pte_addr, update, update_vaddr, update_paddr,
    input  fault, fault_cause, fault_address, busy
  );
endinterface

// File: rtl/lm32_dtlb_walker.sv
// Two-level hardware page-table walker feeding the DTLB refill path.
// One walk at a time; result is either a one-cycle update strobe or a one-cycle fault strobe.
module lm32_dtlb_walker #(
  parameter int unsigned timeout = 32'd255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lm32_dtlb_walker_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_L1    = 3'd1,
    S_L2    = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_va;
  logic        r_store;
  logic        r_pte_req;
  logic [31:0] r_pte_addr;
  logic [31:0] r_cnt;
  logic        r_busy;
  logic [31:0] r_update_vaddr;
  logic [31:0] r_update_paddr;
  logic [1:0]  r_fault_cause;
  logic [31:0] r_fault_address;
  logic [1:0]  w_cause_nx;
  logic        w_tmo;
  logic        w_req_nx;
  logic        w_unused;

  assign w_unused = ^{bus.ptbr[11:0], bus.pte_data[11:2]};

  // Next-state selection, fault cause for a FAULT entry, and timeout detection.
  always_comb begin
    w_state_nx = r_state;
    w_cause_nx = r_fault_cause;
    w_tmo      = 1'b0;
    if ((timeout != 32'd0) && r_pte_req && !bus.pte_ack && (r_cnt == (timeout - 32'd1))) begin
      w_tmo = 1'b1;
    end else begin
      w_tmo = 1'b0;
    end
    case (r_state)
      S_IDLE: begin
        if (bus.enable && bus.miss_i) begin
          w_state_nx = S_L1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_L1, S_L2: begin
        // An abort racing an ack needs no drain; otherwise the outstanding read must complete.
        if (bus.abort) begin
          if (bus.pte_ack) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_DRAIN;
          end
        end else if (bus.pte_ack) begin
          if (bus.pte_err) begin
            w_state_nx = S_FAULT;
            w_cause_nx = 2'b11;
          end else if (!bus.pte_data[0]) begin
            w_state_nx = S_FAULT;
            w_cause_nx = 2'b01;
          end else if ((r_state == S_L2) && r_store && !bus.pte_data[1]) begin
            w_state_nx = S_FAULT;
            w_cause_nx = 2'b10;
          end else if (r_state == S_L1) begin
            w_state_nx = S_L2;
          end else begin
            w_state_nx = S_DONE;
          end
        end else if (w_tmo) begin
          w_state_nx = S_FAULT;
          w_cause_nx = 2'b11;
        end else begin
          w_state_nx = r_state;
        end
      end
      S_DONE, S_FAULT: begin
        w_state_nx = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.pte_ack || w_tmo) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DRAIN;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign w_req_nx = (w_state_nx == S_L1) || (w_state_nx == S_L2) || (w_state_nx == S_DRAIN);

  // State register plus all registered walk context and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_va            <= 32'd0;
      r_store         <= 1'b0;
      r_pte_req       <= 1'b0;
      r_pte_addr      <= 32'd0;
      r_cnt           <= 32'd0;
      r_busy          <= 1'b0;
      r_update_vaddr  <= 32'd0;
      r_update_paddr  <= 32'd0;
      r_fault_cause   <= 2'b00;
      r_fault_address <= 32'd0;
    end else begin
      r_state   <= w_state_nx;
      r_pte_req <= w_req_nx;
      r_busy    <= (w_state_nx != S_IDLE);
      // Each new request phase (L1, L2, drain) gets a fresh timeout budget.
      if ((w_state_nx != r_state) && w_req_nx) begin
        r_cnt <= 32'd0;
      end else if (r_pte_req && !bus.pte_ack) begin
        r_cnt <= r_cnt + 32'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if ((r_state == S_IDLE) && (w_state_nx == S_L1)) begin
        r_va       <= bus.miss_address;
        r_store    <= bus.miss_store;
        r_pte_addr <= {bus.ptbr[31:12], bus.miss_address[31:22], 2'b00};
      end else if ((r_state == S_L1) && (w_state_nx == S_L2)) begin
        r_pte_addr <= {bus.pte_data[31:12], r_va[21:12], 2'b00};
      end else begin
        r_pte_addr <= r_pte_addr;
      end
      if ((r_state == S_L2) && (w_state_nx == S_DONE)) begin
        r_update_vaddr <= {r_va[31:12], 12'h000};
        r_update_paddr <= {bus.pte_data[31:12], 12'h000};
      end else begin
        r_update_vaddr <= r_update_vaddr;
        r_update_paddr <= r_update_paddr;
      end
      if ((w_state_nx == S_FAULT) && (r_state != S_FAULT)) begin
        r_fault_cause   <= w_cause_nx;
        r_fault_address <= r_va;
      end else begin
        r_fault_cause   <= r_fault_cause;
        r_fault_address <= r_fault_address;
      end
    end
  end

  // Strobes are gated by abort and reset within the same cycle they would fire.
  assign bus.update        = (r_state == S_DONE) && !bus.abort && !rst_i;
  assign bus.fault         = (r_state == S_FAULT) && !bus.abort && !rst_i;
  assign bus.pte_req       = r_pte_req;
  assign bus.pte_addr      = r_pte_addr;
  assign bus.update_vaddr  = r_update_vaddr;
  assign bus.update_paddr  = r_update_paddr;
  assign bus.fault_cause   = r_fault_cause;
  assign bus.fault_address = r_fault_address;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Self-checking bench for lm32_dtlb_walker: table vectors, corner-case sequences,
// and randomized walks checked against a page-table reference model.
module tb_lm32_dtlb_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lm32_dtlb_walker_if bus();
  lm32_dtlb_walker #(.timeout(32'd4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [31:0] va;
    logic        store;
    logic [31:0] ptbr;
    logic [31:0] a1;
    logic [31:0] pte1;
    logic [31:0] a2;
    logic [31:0] pte2;
    bit          e1;
    bit          e2;
    int          lat1;
    int          lat2;
    bit          exp_upd;
    logic [1:0]  exp_cause;
    logic [31:0] exp_uv;
    logic [31:0] exp_up;
    int          exp_cyc;
    int          exp_nacks;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit [31:0] mem [bit [31:0]];
  bit        errmap [bit [31:0]];
  int        lat_q[$];
  bit [31:0] acked[$];
  int        cur_lat = 0;
  int        wcnt = 0;
  bit        have_lat = 1'b0;

  logic        d_rst = 1'b1, d_en = 1'b0, d_miss = 1'b0, d_store = 1'b0, d_abort = 1'b0;
  logic [31:0] d_va = 32'd0, d_ptbr = 32'd0;

  logic        s_req, s_upd, s_flt, s_busy;
  logic [31:0] s_addr, s_uv, s_up, s_fa;
  logic [1:0]  s_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, answer the PTE port, sample outputs 1ns later.
  task automatic tick();
    @(negedge clk);
    rst              = d_rst;
    bus.enable       = d_en;
    bus.miss_i       = d_miss;
    bus.miss_address = d_va;
    bus.miss_store   = d_store;
    bus.ptbr         = d_ptbr;
    bus.abort        = d_abort;
    if (bus.pte_req === 1'b1) begin
      if (!have_lat) begin
        cur_lat  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        wcnt     = 0;
        have_lat = 1'b1;
      end
      if (wcnt == cur_lat) begin
        bus.pte_ack  = 1'b1;
        bus.pte_data = mem.exists(bus.pte_addr) ? mem[bus.pte_addr] : 32'h0;
        bus.pte_err  = errmap.exists(bus.pte_addr);
        acked.push_back(bus.pte_addr);
        have_lat = 1'b0;
      end else begin
        bus.pte_ack  = 1'b0;
        bus.pte_err  = 1'($urandom_range(0, 1));
        bus.pte_data = $urandom;
        wcnt++;
      end
    end else begin
      bus.pte_ack  = 1'b0;
      bus.pte_err  = 1'($urandom_range(0, 1));
      bus.pte_data = $urandom;
      have_lat     = 1'b0;
    end
    #1;
    s_req  = bus.pte_req;
    s_addr = bus.pte_addr;
    s_upd  = bus.update;
    s_uv   = bus.update_vaddr;
    s_up   = bus.update_paddr;
    s_flt  = bus.fault;
    s_fc   = bus.fault_cause;
    s_fa   = bus.fault_address;
    s_busy = bus.busy;
    check1("upd_fault_exclusive", s_upd & s_flt, 1'b0);
  endtask

  function automatic vec_t mkv(logic [31:0] va, logic st, logic [31:0] ptbr,
                               logic [31:0] a1, logic [31:0] p1, logic [31:0] a2, logic [31:0] p2,
                               bit e1, bit e2, int l1, int l2, bit upd, logic [1:0] cause,
                               logic [31:0] uv, logic [31:0] up, int cyc, int nacks);
    vec_t v;
    v.va = va; v.store = st; v.ptbr = ptbr; v.a1 = a1; v.pte1 = p1; v.a2 = a2; v.pte2 = p2;
    v.e1 = e1; v.e2 = e2; v.lat1 = l1; v.lat2 = l2; v.exp_upd = upd; v.exp_cause = cause;
    v.exp_uv = uv; v.exp_up = up; v.exp_cyc = cyc; v.exp_nacks = nacks;
    return v;
  endfunction

  // Reference: walk the table by the page-table rules and predict outcome and timing.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int   t1, t2;
    r.a1 = {v.ptbr[31:12], v.va[31:22], 2'b00};
    r.a2 = {v.pte1[31:12], v.va[21:12], 2'b00};
    r.exp_uv = 32'd0; r.exp_up = 32'd0; r.exp_cause = 2'b00; r.exp_upd = 1'b0;
    t1 = 1 + v.lat1;
    t2 = t1 + 1 + v.lat2;
    if (v.e1 || !v.pte1[0]) begin
      r.exp_cause = v.e1 ? 2'b11 : 2'b01;
      r.exp_cyc = t1 + 1; r.exp_nacks = 1;
    end else begin
      r.exp_cyc = t2 + 1; r.exp_nacks = 2;
      if (v.e2) r.exp_cause = 2'b11;
      else if (!v.pte2[0]) r.exp_cause = 2'b01;
      else if (v.store && !v.pte2[1]) r.exp_cause = 2'b10;
      else begin
        r.exp_upd = 1'b1;
        r.exp_uv = {v.va[31:12], 12'h000};
        r.exp_up = {v.pte2[31:12], 12'h000};
      end
    end
    return r;
  endfunction

  task automatic load_mem(input vec_t v);
    mem.delete(); errmap.delete(); acked.delete(); lat_q.delete();
    mem[v.a1] = v.pte1;
    mem[v.a2] = v.pte2;
    if (v.e1) errmap[v.a1] = 1'b1;
    if (v.e2) errmap[v.a2] = 1'b1;
    lat_q.push_back(v.lat1);
    lat_q.push_back(v.lat2);
  endtask

  // Full walk with miss_i held high throughout; scramble perturbs inputs the walker must ignore.
  task automatic run_walk(input vec_t v, input bit scramble);
    int rel = 0;
    bit seen = 1'b0;
    load_mem(v);
    d_en = 1'b1; d_miss = 1'b1; d_va = v.va; d_store = v.store; d_ptbr = v.ptbr; d_abort = 1'b0;
    tick();
    check1("busy_at_c0", s_busy, 1'b0);
    while (!seen && rel < 40) begin
      if (scramble) begin
        d_va = $urandom; d_ptbr = $urandom;
        d_store = 1'($urandom_range(0, 1)); d_en = 1'($urandom_range(0, 1));
      end
      tick();
      rel++;
      if (s_upd || s_flt) seen = 1'b1;
      else check1("busy_during_walk", s_busy, 1'b1);
    end
    check1("strobe_seen", seen, 1'b1);
    if (seen) begin
      check("strobe_cycle", rel, v.exp_cyc);
      check1("update", s_upd, v.exp_upd);
      check1("fault", s_flt, !v.exp_upd);
      if (v.exp_upd) begin
        check("update_vaddr", s_uv, v.exp_uv);
        check("update_paddr", s_up, v.exp_up);
      end else begin
        check("fault_cause", {30'd0, s_fc}, {30'd0, v.exp_cause});
        check("fault_address", s_fa, v.va);
      end
    end
    d_miss = 1'b0; d_en = 1'b1;
    tick();
    check1("busy_gap", s_busy, 1'b0);
    check1("no_strobe_after", s_upd | s_flt, 1'b0);
    if (v.exp_upd) check("update_paddr_held", s_up, v.exp_up);
    else check("fault_address_held", s_fa, v.va);
    check("ack_count", acked.size(), v.exp_nacks);
    if (acked.size() > 0) check("l1_addr", acked[0], v.a1);
    if (acked.size() > 1) check("l2_addr", acked[1], v.a2);
  endtask

  vec_t tbl[10];
  vec_t v0;
  vec_t rv;

  initial begin
    tbl[0] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D003, 0, 0, 0, 0, 1, 2'b00, 32'h4000_5000, 32'h0ABC_D000, 3, 2);
    tbl[1] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0000, 32'h0020_0014,
                 32'h0ABC_D003, 0, 0, 0, 0, 0, 2'b01, 32'h0, 32'h0, 2, 1);
    tbl[2] = mkv(32'h4000_5123, 1'b1, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D001, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 3, 2);
    tbl[3] = mkv(32'h4000_5123, 1'b1, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D003, 0, 0, 0, 0, 1, 2'b00, 32'h4000_5000, 32'h0ABC_D000, 3, 2);
    tbl[4] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D003, 0, 0, 2, 1, 1, 2'b00, 32'h4000_5000, 32'h0ABC_D000, 6, 2);
    tbl[5] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D003, 1, 0, 0, 0, 0, 2'b11, 32'h0, 32'h0, 2, 1);
    tbl[6] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D003, 0, 1, 0, 2, 0, 2'b11, 32'h0, 32'h0, 5, 2);
    tbl[7] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0000_0002, 0, 0, 0, 0, 0, 2'b01, 32'h0, 32'h0, 3, 2);
    tbl[8] = mkv(32'hFFC0_0FFF, 1'b0, 32'h8765_4321, 32'h8765_4FFC, 32'h1234_5001, 32'h1234_5000,
                 32'hFEDC_B003, 0, 0, 0, 0, 1, 2'b00, 32'hFFC0_0000, 32'hFEDC_B000, 3, 2);
    tbl[9] = mkv(32'h4000_5123, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0020_0001, 32'h0020_0014,
                 32'h0ABC_D003, 0, 0, 3, 3, 1, 2'b00, 32'h4000_5000, 32'h0ABC_D000, 9, 2);
    v0 = tbl[0];

    // Reset state
    d_rst = 1'b1;
    tick(); tick();
    check1("rst_req", s_req, 1'b0);
    check("rst_addr", s_addr, 32'd0);
    check1("rst_update", s_upd, 1'b0);
    check("rst_uv", s_uv, 32'd0);
    check("rst_up", s_up, 32'd0);
    check1("rst_fault", s_flt, 1'b0);
    check("rst_fc", {30'd0, s_fc}, 32'd0);
    check("rst_fa", s_fa, 32'd0);
    check1("rst_busy", s_busy, 1'b0);
    d_rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_walk(tbl[i], 1'b0);

    // Miss ignored while MMU disabled
    d_en = 1'b0; d_miss = 1'b1; d_va = v0.va; d_ptbr = v0.ptbr;
    tick(); tick();
    check1("disabled_busy", s_busy, 1'b0);
    check1("disabled_req", s_req, 1'b0);
    d_miss = 1'b0; d_en = 1'b1;

    // L1 ack never returns: timeout after 4 request cycles
    load_mem(v0); lat_q.delete(); lat_q.push_back(1000);
    d_miss = 1'b1; tick(); d_miss = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check1("tmo_req_held", s_req, 1'b1);
      check1("tmo_no_fault_yet", s_flt, 1'b0);
    end
    tick();
    check1("tmo_fault", s_flt, 1'b1);
    check("tmo_cause", {30'd0, s_fc}, 32'd3);
    check("tmo_fa", s_fa, v0.va);
    check1("tmo_req_low", s_req, 1'b0);
    tick();
    check1("tmo_idle", s_busy, 1'b0);

    // Abort while L2 request pending; ack arrives 3 cycles later
    load_mem(v0); lat_q.delete(); lat_q.push_back(0); lat_q.push_back(3);
    d_miss = 1'b1; tick(); d_miss = 1'b0;
    tick();
    d_abort = 1'b1; tick(); d_abort = 1'b0;
    check1("abort_l2_req", s_req, 1'b1);
    check1("abort_l2_nostrobe", s_upd | s_flt, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check1("drain_req", s_req, 1'b1);
      check1("drain_busy", s_busy, 1'b1);
      check1("drain_nostrobe", s_upd | s_flt, 1'b0);
    end
    tick();
    check1("drain_done_req", s_req, 1'b0);
    check1("drain_done_busy", s_busy, 1'b0);
    check1("drain_done_nostrobe", s_upd | s_flt, 1'b0);
    check("drain_acks", acked.size(), 2);
    run_walk(v0, 1'b0);

    // Abort in L1 with ack in the same cycle: straight back to idle
    load_mem(v0); lat_q.delete(); lat_q.push_back(0);
    d_miss = 1'b1; tick(); d_miss = 1'b0;
    d_abort = 1'b1; tick(); d_abort = 1'b0;
    check1("abort_l1_req", s_req, 1'b1);
    tick();
    check1("abort_l1_idle_req", s_req, 1'b0);
    check1("abort_l1_idle_busy", s_busy, 1'b0);

    // Abort in DONE suppresses update
    load_mem(v0);
    d_miss = 1'b1; tick(); d_miss = 1'b0;
    tick(); tick();
    d_abort = 1'b1; tick(); d_abort = 1'b0;
    check1("abort_done_noupd", s_upd, 1'b0);
    check1("abort_done_busy", s_busy, 1'b1);
    tick();
    check1("abort_done_idle", s_busy, 1'b0);

    // Reset mid-walk
    load_mem(v0);
    d_miss = 1'b1; tick(); d_miss = 1'b0;
    tick();
    d_rst = 1'b1; tick(); d_rst = 1'b0;
    tick();
    check1("midrst_req", s_req, 1'b0);
    check1("midrst_busy", s_busy, 1'b0);
    check1("midrst_nostrobe", s_upd | s_flt, 1'b0);
    tick();
    check1("midrst_still_idle", s_upd | s_flt | s_busy, 1'b0);

    // Randomized walks against the reference model
    for (int n = 0; n < 40; n++) begin
      rv.va    = $urandom;
      rv.store = 1'($urandom_range(0, 1));
      rv.ptbr  = $urandom & 32'h7FFF_FFFF;
      rv.pte1  = $urandom | 32'h8000_0000;
      rv.pte1[0] = ($urandom_range(0, 4) != 0);
      rv.pte2  = $urandom;
      rv.pte2[0] = ($urandom_range(0, 4) != 0);
      rv.e1    = ($urandom_range(0, 9) == 0);
      rv.e2    = ($urandom_range(0, 9) == 0);
      rv.lat1  = $urandom_range(0, 3);
      rv.lat2  = $urandom_range(0, 3);
      run_walk(model(rv), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
